// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions for the character-LCD driver and monitor.
// Command masks, DDRAM geometry, and address-step helpers.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_FSET  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] ROW0_BASE    = 7'h00;
  localparam logic [6:0] ROW1_BASE    = 7'h40;
  localparam logic [6:0] LINE_LAST    = 7'h27;
  localparam logic [6:0] ROW1_LAST    = ROW1_BASE + LINE_LAST;
  localparam int         VISIBLE_COLS = 16;

  localparam logic [7:0] FILL_DEFAULT = 8'h20;

  typedef enum logic { PH_HI, PH_LO } nib_phase_e;
  typedef enum logic { TGT_DDRAM, TGT_CGRAM } target_e;

  // Two 40-char lines live at 0x00-0x27 and 0x40-0x67; the counter hops the gaps.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == LINE_LAST)      r = ROW1_BASE;
      else if (a == ROW1_LAST) r = ROW0_BASE;
      else                     r = a + 7'd1;
    end else begin
      if (a == ROW0_BASE)      r = ROW1_LAST;
      else if (a == ROW1_BASE) r = LINE_LAST;
      else                     r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic ddram_legal(input logic [6:0] a);
    return (a <= LINE_LAST) || ((a >= ROW1_BASE) && (a <= ROW1_LAST));
  endfunction

endpackage

// File: rtl/lcd_pin_sync.sv
// Synchronizes the LCD pins and emits a one-cycle strobe on each falling E
// of a write, with RS/D taken from the same stage as E.
module lcd_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [3:0] d,
  output logic       strobe,
  output logic       rs_s,
  output logic [3:0] d_s
);

  // Per stage: {e, rw, rs, d[3:0]}
  logic [SYNC_STAGES-1:0][6:0] pipe;
  logic [6:0]                  tap;
  logic                        e_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe   <= '0;
      e_prev <= 1'b0;
    end else begin
      pipe   <= {pipe[SYNC_STAGES-2:0], {e, rw, rs, d}};
      e_prev <= pipe[SYNC_STAGES-1][6];
    end
  end

  assign tap    = pipe[SYNC_STAGES-1];
  assign strobe = e_prev & ~tap[6] & ~tap[5];
  assign rs_s   = tap[4];
  assign d_s    = tap[3:0];

endmodule

// File: rtl/lcd_monitor.sv
// HD44780 4-bit write-protocol decoder that rebuilds the two visible rows
// as 128-bit ASCII vectors, column 0 in the top byte.
module lcd_monitor
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_CHAR   = FILL_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_is_data,
  output logic         four_bit,
  output logic         addr_err
);

  logic       strobe, rs_s;
  logic [3:0] d_s;

  lcd_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .e      (LCD_E),
    .rs     (LCD_RS),
    .rw     (LCD_RW),
    .d      (LCD_D),
    .strobe (strobe),
    .rs_s   (rs_s),
    .d_s    (d_s)
  );

  logic [VISIBLE_COLS-1:0][7:0] row_a, row_b;
  logic [6:0]  addr;
  logic        inc;
  nib_phase_e  phase, phase_nxt;
  target_e     target;
  logic [3:0]  hi_nib, hi_nib_nxt;
  logic        hi_rs, hi_rs_nxt;
  logic        done, cur_rs;
  logic [7:0]  cur_byte;

  // Byte assembly: one strobe per byte in 8-bit mode, two in 4-bit mode.
  always_comb begin
    phase_nxt  = phase;
    hi_nib_nxt = hi_nib;
    hi_rs_nxt  = hi_rs;
    done       = 1'b0;
    cur_byte   = '0;
    cur_rs     = 1'b0;
    if (strobe) begin
      if (!four_bit) begin
        done     = 1'b1;
        cur_byte = {d_s, 4'h0};
        cur_rs   = rs_s;
      end else if (phase == PH_HI) begin
        hi_nib_nxt = d_s;
        hi_rs_nxt  = rs_s;
        phase_nxt  = PH_LO;
      end else begin
        done      = 1'b1;
        cur_byte  = {hi_nib, d_s};
        cur_rs    = hi_rs;
        phase_nxt = PH_HI;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_a        <= {VISIBLE_COLS{FILL_CHAR}};
      row_b        <= {VISIBLE_COLS{FILL_CHAR}};
      addr         <= ROW0_BASE;
      inc          <= 1'b1;
      phase        <= PH_HI;
      target       <= TGT_DDRAM;
      four_bit     <= 1'b0;
      hi_nib       <= '0;
      hi_rs        <= 1'b0;
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      byte_valid <= done;
      addr_err   <= 1'b0;
      phase      <= phase_nxt;
      hi_nib     <= hi_nib_nxt;
      hi_rs      <= hi_rs_nxt;
      if (done) begin
        byte_out     <= cur_byte;
        byte_is_data <= cur_rs;
        if (!cur_rs) begin
          // Highest set bit selects the command.
          if (|(cur_byte & CMD_DDRAM)) begin
            if (ddram_legal(cur_byte[6:0])) begin
              addr   <= cur_byte[6:0];
              target <= TGT_DDRAM;
            end else begin
              addr_err <= 1'b1;
            end
          end else if (|(cur_byte & CMD_CGRAM)) begin
            target <= TGT_CGRAM;
          end else if (|(cur_byte & CMD_FSET)) begin
            if (!four_bit && !cur_byte[4]) begin
              four_bit <= 1'b1;
              phase    <= PH_HI;
            end
          end else if (|(cur_byte[4:3])) begin
            // Display control / shift: nothing to model
          end else if (|(cur_byte & CMD_ENTRY)) begin
            inc <= cur_byte[1];
          end else if (|(cur_byte & CMD_HOME)) begin
            addr   <= ROW0_BASE;
            target <= TGT_DDRAM;
          end else if (|(cur_byte & CMD_CLEAR)) begin
            row_a  <= {VISIBLE_COLS{FILL_CHAR}};
            row_b  <= {VISIBLE_COLS{FILL_CHAR}};
            addr   <= ROW0_BASE;
            inc    <= 1'b1;
            target <= TGT_DDRAM;
          end
        end else if (target == TGT_DDRAM) begin
          if (addr[6:4] == ROW0_BASE[6:4]) row_a[~addr[3:0]] <= cur_byte;
          if (addr[6:4] == ROW1_BASE[6:4]) row_b[~addr[3:0]] <= cur_byte;
          addr <= addr_step(addr, inc);
        end
      end
    end
  end

  assign row_A = row_a;
  assign row_B = row_b;

endmodule

// File: doc/lcd_monitor.md
Name: lcd_monitor

Overview:
- Receive-side counterpart of the team's character-LCD driver.
- Sits on the LCD_E/LCD_RS/LCD_RW/LCD_D pins, which are driven by the lcd controller or by an external source during loopback.
- Decodes the HD44780 4-bit write protocol: command vs data, the 8-bit-mode init nibbles, and DDRAM addressing.
- Reconstructs the two visible 16-character rows as 128-bit ASCII vectors in the same packing the driver consumes, so rows can be compared or fed back for on-board self-check.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer chain, minimum 2.
- FILL_CHAR, 8'h20, character written to every row position on reset and on Clear Display.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- LCD_E  input  1  enable strobe; a write is captured on its falling edge.
- LCD_RS  input  1  0 = command, 1 = data.
- LCD_RW  input  1  0 = write, 1 = read; reads are ignored.
- LCD_D  input  4  data nibble.
- row_A  output  128  row 0 (DDRAM 0x00-0x0F); column 0 in [127:120].
- row_B  output  128  row 1 (DDRAM 0x40-0x4F); column 0 in [127:120].
- byte_valid  output  1  one-cycle pulse when a complete byte is decoded.
- byte_out  output  8  decoded byte, valid with byte_valid.
- byte_is_data  output  1  RS value of that byte, valid with byte_valid.
- four_bit  output  1  1 once the interface has switched to 4-bit mode.
- addr_err  output  1  one-cycle pulse on an illegal Set DDRAM address.

Behaviour:
- Reset values:
  - row_A = row_B = {16{FILL_CHAR}}.
  - byte_valid = 0, byte_out = 0, byte_is_data = 0, four_bit = 0, addr_err = 0.
  - Internal: addr = 0, inc = 1, nib_phase = HI, target = DDRAM.
- Synchronizer and edge detect:
  - All four inputs pass through SYNC_STAGES flops.
  - A strobe is the synchronized E going 1 to 0 while synchronized RW = 0.
  - RS and D are taken from the same synchronized stage as E.
  - Strobes with RW = 1 are discarded and leave nib_phase untouched.
- Source timing requirement: E high ≥ SYNC_STAGES+1 cycles, E low ≥ SYNC_STAGES+1 cycles, RS/D stable across the falling edge.
- Latency (SYNC_STAGES = 2): byte_valid and all row/addr updates occur on the 3rd rising clk edge after the first edge that samples the E pin low.
- 8-bit mode (four_bit = 0):
  - Each strobe is a complete byte = {D, 4'h0}.
  - A byte matching 0x2X (function set, DL = 0) sets four_bit = 1 and clears nib_phase to HI.
  - 0x3X bytes are consumed with no other effect.
- 4-bit mode (four_bit = 1):
  - HI strobe latches the upper nibble and RS, with no output.
  - LO strobe completes the byte using the RS latched at HI; an RS mismatch between the halves is ignored.
  - Phase toggles on every accepted strobe.
- Commands (RS = 0), priority by highest set bit:
  - 1xxxxxxx Set DDRAM: addr ∈ 0x00-0x27 or 0x40-0x67 → addr = byte[6:0], target = DDRAM. Otherwise addr_err pulses and addr/target are unchanged.
  - 01xxxxxx Set CGRAM: target = CGRAM.
  - 001xxxxx Function set: no effect in 4-bit mode.
  - 0001xxxx and 00001xxx: no effect.
  - 000001xx Entry mode: inc = bit1; shift bit ignored.
  - 0000001x Return Home: addr = 0, target = DDRAM.
  - 00000001 Clear Display: both rows filled with FILL_CHAR, addr = 0, inc = 1, target = DDRAM.
- Data (RS = 1):
  - If target = CGRAM, the byte is discarded.
  - Otherwise, if addr is 0x00-0x0F, write row_A column addr. If addr is 0x40-0x4F, write row_B column addr-0x40.
  - The address then advances even when the write is off-screen.
- Address advance:
  - Increment: 0x27 → 0x40, 0x67 → 0x00, else +1.
  - Decrement: 0x00 → 0x67, 0x40 → 0x27, else -1.
- Simultaneous events: rst has priority over any strobe in the same cycle.
- Mid-operation reset: a half-received byte is dropped; nib_phase returns to HI and four_bit returns to 0.

Decomposition:
- Shared package lcd_pkg holds:
  - Command opcode masks: CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DDRAM, CMD_CGRAM, CMD_FSET.
  - ROW0_BASE 7'h00, ROW1_BASE 7'h40, LINE_LAST 7'h27, VISIBLE_COLS 16.
  - Default fill 8'h20.
  - The same package serves the lcd driver.
- Sub-module lcd_pin_sync holds the SYNC_STAGES synchronizer plus falling-edge detect, and outputs strobe, rs_s and d_s.

Test Plan:
- Reset → row_A = row_B = 128'h2020…20, four_bit = 0, no byte_valid.
- Init: nibbles 3,3,3,2 (RS = 0), then 0x28, 0x06, 0x0C, 0x01 in 4-bit mode → four_bit = 1 after the 4th strobe; byte_valid ×8 with byte_out 30,30,30,20,28,06,0C,01; rows all 0x20.
- After init, 0x80 then data "Hello, World!" then 0xC0 then "Demo of the LCD." → row_A = 128'h48656C6C6F2C20576F726C6421202020, row_B = 128'h44656D6F206F6620746865204C43442E.
- Entry mode 0x04, set addr 0x8F, write 'A','B' → row_A[7:0] = 0x41 and row_A[15:8] = 0x42; then 0xC0 and one data byte with decrement → addr wraps 0x40 → 0x27, and the next write leaves the rows unchanged.
- Set addr 0xAA → addr_err pulses one cycle and the next data byte lands at the previous address. Set CGRAM 0x40, then data 0x55 → rows unchanged.
- Assert rst between the HI and LO nibbles of 0x41 → no byte_valid. After the full init is repeated, 0x80 then 'Z' → row_A[127:120] = 0x5A.
